// File: rtl/axil_console_pkg.sv
// Shared constants for the AXI-Lite console: register map, response codes and
// the bit layout of the STATUS and CTRL registers.
package axil_console_pkg;

  localparam logic [4:0] OFF_ID     = 5'h00;
  localparam logic [4:0] OFF_TXDATA = 5'h04;
  localparam logic [4:0] OFF_STATUS = 5'h08;
  localparam logic [4:0] OFF_CTRL   = 5'h0C;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  localparam logic [31:0] ID_VALUE = 32'h4355_4F4E;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_LVL_LSB   = 8;
  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_CLR_OVF = 1;

endpackage

// File: rtl/axil_console_if.sv
// Plain 32-bit AXI-Lite bundle with master and slave views.
interface AXI_LITE;
  logic [31:0] aw_addr;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] ar_addr;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;

  modport Master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport Slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axil_console_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is accepted
// only when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (level_o == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; clearing the pointers already discards it and
  // keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/axil_console.sv
// AXI-Lite character console: buffers TXDATA writes in a FIFO and drains them
// one byte every DRAIN_DIV cycles to a byte stream (and the simulator console).
module axil_console
  import axil_console_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DRAIN_DIV  = 4,
  parameter int ECHO       = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  AXI_LITE.Slave     axi,
  output logic       tx_valid_o,
  output logic [7:0] tx_byte_o
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  logic             aw_held_q, w_held_q, b_valid_q, r_valid_q;
  logic [4:0]       aw_off_q;
  logic [7:0]       w_byte_q;
  logic             w_strb0_q;
  resp_e            b_resp_q, b_resp_d, r_resp_q, r_resp_d;
  logic [31:0]      r_data_q, r_data_d, status;
  logic             tx_en_q, ovf_q, tx_valid_q;
  logic [7:0]       tx_byte_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             aw_hs, w_hs, ar_hs, b_hs, r_hs, commit;
  logic             wr_txdata, wr_ctrl, push, pop, ovf_set, ovf_clr;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic [7:0]       fifo_rdata;
  logic             unused_bits;

  assign axi.aw_ready = ~aw_held_q;
  assign axi.w_ready  = ~w_held_q;
  assign axi.b_valid  = b_valid_q;
  assign axi.b_resp   = b_resp_q;
  assign axi.ar_ready = ~r_valid_q;
  assign axi.r_valid  = r_valid_q;
  assign axi.r_resp   = r_resp_q;
  assign axi.r_data   = r_data_q;
  assign tx_valid_o   = tx_valid_q;
  assign tx_byte_o    = tx_byte_q;

  assign unused_bits = ^{axi.aw_addr[31:5], axi.ar_addr[31:5], axi.w_data[31:8], axi.w_strb[3:1]};

  assign aw_hs  = axi.aw_valid & ~aw_held_q;
  assign w_hs   = axi.w_valid & ~w_held_q;
  assign ar_hs  = axi.ar_valid & ~r_valid_q;
  assign b_hs   = b_valid_q & axi.b_ready;
  assign r_hs   = r_valid_q & axi.r_ready;
  // A write commits exactly once: on the edge that raises b_valid.
  assign commit = aw_held_q & w_held_q & ~b_valid_q;

  assign wr_txdata = (aw_off_q == OFF_TXDATA);
  assign wr_ctrl   = (aw_off_q == OFF_CTRL);
  assign push      = commit & wr_txdata & w_strb0_q;
  assign pop       = tx_en_q & ~fifo_empty & (cnt_q == CNT_W'(DRAIN_DIV - 1));
  assign ovf_set   = push & fifo_full & ~pop;
  assign ovf_clr   = commit & wr_ctrl & w_byte_q[CTRL_CLR_OVF];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    b_resp_d = RESP_SLVERR;
    if (wr_txdata || wr_ctrl) b_resp_d = RESP_OKAY;

    cnt_d = cnt_q;
    if (fifo_empty || pop) cnt_d = '0;
    else if (tx_en_q)      cnt_d = cnt_q + 1'b1;

    status                     = '0;
    status[ST_EMPTY]           = fifo_empty;
    status[ST_FULL]            = fifo_full;
    status[ST_OVF]             = ovf_q;
    status[ST_LVL_LSB +: 8]    = 8'(fifo_level);

    r_data_d = '0;
    r_resp_d = RESP_OKAY;
    case (axi.ar_addr[4:0])
      OFF_ID:     r_data_d = ID_VALUE;
      OFF_STATUS: r_data_d = status;
      OFF_CTRL:   r_data_d[CTRL_TX_EN] = tx_en_q;
      default:    r_resp_d = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_q  <= 1'b0;
      aw_off_q   <= '0;
      w_held_q   <= 1'b0;
      w_byte_q   <= '0;
      w_strb0_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      r_valid_q  <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
      tx_en_q    <= 1'b1;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_off_q  <= axi.aw_addr[4:0];
      end
      if (w_hs) begin
        w_held_q  <= 1'b1;
        w_byte_q  <= axi.w_data[7:0];
        w_strb0_q <= axi.w_strb[0];
      end
      if (commit) begin
        b_valid_q <= 1'b1;
        b_resp_q  <= b_resp_d;
        if (wr_ctrl) tx_en_q <= w_byte_q[CTRL_TX_EN];
      end else if (b_hs) begin
        b_valid_q <= 1'b0;
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end

      if (ar_hs) begin
        r_valid_q <= 1'b1;
        r_data_q  <= r_data_d;
        r_resp_q  <= r_resp_d;
      end else if (r_hs) begin
        r_valid_q <= 1'b0;
      end

      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;

      cnt_q      <= cnt_d;
      tx_valid_q <= pop;
      if (pop) tx_byte_q <= fifo_rdata;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (w_byte_q),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

`ifndef SYNTHESIS
  generate
    if (ECHO != 0) begin : g_echo
      always_ff @(posedge clk) begin
        if (pop) $write("%c", fifo_rdata);
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_axil_console.sv
// Randomised self-checking bench for axil_console against a queue-based model
// of the register map, FIFO contents and output byte order.
module tb_axil_console;
  import axil_console_pkg::*;

  localparam int DEPTH = 16;
  localparam int DIV   = 4;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_byte;

  AXI_LITE axi();

  axil_console #(.FIFO_DEPTH(DEPTH), .DRAIN_DIV(DIV), .ECHO(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axi        (axi),
    .tx_valid_o (tx_valid),
    .tx_byte_o  (tx_byte)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes accepted and not yet seen on the stream, plus flags.
  logic [7:0] exp_q[$];
  bit         model_ovf;
  bit         model_tx_en;

  int         pulse_cnt = 0;
  int         last_pulse = 0;
  bit         gap_arm = 0;
  int         gap_prev = -1;
  int         gap_min = 1000;
  int         gap_max = 0;
  int         wr_commit_cyc = 0;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (rst_n && tx_valid) begin
      if (exp_q.size() == 0) begin
        check("tx_unexpected", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tx_byte", tx_byte, mon_exp);
      end
      if (gap_arm) begin
        if (gap_prev >= 0) begin
          if (cyc - gap_prev < gap_min) gap_min = cyc - gap_prev;
          if (cyc - gap_prev > gap_max) gap_max = cyc - gap_prev;
        end
        gap_prev = cyc;
      end
      last_pulse = cyc;
      pulse_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, output logic [1:0] resp, output int lat);
    int aw_at, w_at, c, n;
    bit aw_done, w_done, aw_fire, w_fire;
    aw_at = (lead < 0) ? -lead : 0;
    w_at  = (lead > 0) ? lead : 0;
    c = 0; aw_done = 0; w_done = 0;
    resp = 2'b11; lat = 0;
    axi.aw_addr = addr; axi.w_data = data; axi.w_strb = strb;
    while (!(aw_done && w_done) && c < 50) begin
      if (!aw_done && c >= aw_at) axi.aw_valid = 1'b1;
      if (!w_done && c >= w_at)   axi.w_valid = 1'b1;
      @(negedge clk);
      aw_fire = axi.aw_valid && axi.aw_ready;
      w_fire  = axi.w_valid && axi.w_ready;
      if (aw_done && !w_done) check("w_ready_wait", axi.w_ready, 1);
      if (w_done && !aw_done) check("aw_ready_wait", axi.aw_ready, 1);
      @(posedge clk); #1;
      if (aw_fire) begin axi.aw_valid = 1'b0; aw_done = 1; end
      if (w_fire)  begin axi.w_valid = 1'b0;  w_done = 1;  end
      c++;
    end
    if (!(aw_done && w_done)) check("wr_handshake_timeout", 0, 1);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (axi.b_valid) break;
    end
    if (axi.b_valid) begin
      resp = axi.b_resp;
      lat = n;
      wr_commit_cyc = cyc;
    end else begin
      check("b_timeout", 0, 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    int n;
    data = '0; resp = 2'b11; lat = 0;
    axi.ar_addr = addr;
    axi.ar_valid = 1'b1;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (axi.ar_ready) break;
    end
    if (!axi.ar_ready) check("ar_timeout", 0, 1);
    @(posedge clk); #1;
    axi.ar_valid = 1'b0;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (axi.r_valid) break;
    end
    if (axi.r_valid) begin
      data = axi.r_data; resp = axi.r_resp; lat = n;
    end else begin
      check("r_timeout", 0, 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] off, input logic [7:0] b, input bit s0, input int lead, input string tag);
    logic [31:0] addr, data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp, resp;
    int          lat;
    addr = {27'($urandom()), off};
    data = {24'($urandom()), b};
    strb = {3'($urandom()), s0};
    exp_resp = (off == 5'h04 || off == 5'h0C) ? OKAY : SLVERR;
    axi_write(addr, data, strb, lead, resp, lat);
    check({tag, "_bresp"}, resp, exp_resp);
    check({tag, "_blat"}, lat, 2);
    if (off == 5'h04 && s0) begin
      if (exp_q.size() >= DEPTH) model_ovf = 1;
      else exp_q.push_back(b);
    end else if (off == 5'h0C) begin
      model_tx_en = b[0];
      if (b[1]) model_ovf = 0;
    end
  endtask

  task automatic rd(input logic [4:0] off, input string tag);
    logic [31:0] exp_d, d;
    logic [1:0]  exp_r, r;
    int          lat;
    exp_d = '0;
    exp_r = OKAY;
    case (off)
      5'h00: exp_d = 32'h4355_4F4E;
      5'h08: exp_d = {16'h0, 8'(exp_q.size()), 5'h0, model_ovf, exp_q.size() == DEPTH, exp_q.size() == 0};
      5'h0C: exp_d = {31'h0, model_tx_en};
      default: exp_r = SLVERR;
    endcase
    axi_read({27'($urandom()), off}, d, r, lat);
    check({tag, "_rresp"}, r, exp_r);
    check({tag, "_rdata"}, d, exp_d);
    check({tag, "_rlat"}, lat, 1);
  endtask

  task automatic wait_pulse(input string tag);
    int p0, n;
    p0 = pulse_cnt;
    n = 0;
    while (pulse_cnt == p0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (pulse_cnt == p0) check({tag, "_timeout"}, 0, 1);
    else check(tag, last_pulse - wr_commit_cyc, DIV);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [4:0] bad_offs [8];

  initial begin
    bad_offs = '{5'h10, 5'h14, 5'h18, 5'h1C, 5'h01, 5'h0A, 5'h00, 5'h08};
    axi.aw_valid = 0; axi.w_valid = 0; axi.ar_valid = 0;
    axi.aw_addr = 0; axi.w_data = 0; axi.w_strb = 0; axi.ar_addr = 0;
    axi.b_ready = 1; axi.r_ready = 1;
    model_tx_en = 1; model_ovf = 0;

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", {axi.aw_ready, axi.w_ready, axi.ar_ready}, 3'b111);
    check("reset_valid", {axi.b_valid, axi.r_valid, tx_valid}, 3'b000);
    check("reset_data", {axi.b_resp, axi.r_resp, axi.r_data, tx_byte}, 0);
    @(posedge clk); #1;

    rd(OFF_ID, "id");
    rd(OFF_STATUS, "status_reset");

    wr(OFF_TXDATA, 8'h48, 1'b1, 2, "tx48");
    wait_pulse("tx48_first_lat");
    wr(OFF_TXDATA, 8'h69, 1'b1, 2, "tx69");
    wait_pulse("tx69_first_lat");

    // Fill past full with draining frozen, then clear overflow and resume.
    wr(OFF_CTRL, 8'h00, 1'b1, 0, "ctrl_off");
    for (int i = 0; i < DEPTH + 1; i++) wr(OFF_TXDATA, 8'($urandom()), 1'b1, int'($urandom_range(0, 4)) - 2, "fill");
    rd(OFF_STATUS, "status_full_ovf");
    rd(OFF_CTRL, "ctrl_off_rd");
    gap_prev = -1; gap_min = 1000; gap_max = 0; gap_arm = 1;
    wr(OFF_CTRL, 8'h03, 1'b1, 0, "ctrl_clr");
    rd(OFF_STATUS, "status_after_clr");
    wait_drain("drain_full");
    gap_arm = 0;
    check("gap_min", gap_min, DIV);
    check("gap_max", gap_max, DIV);
    rd(OFF_STATUS, "status_drained");

    // Illegal accesses must leave FIFO and registers untouched.
    wr(OFF_CTRL, 8'h00, 1'b1, 0, "ctrl_off2");
    wr(OFF_TXDATA, 8'h41, 1'b1, -1, "pre_a");
    wr(OFF_TXDATA, 8'h42, 1'b1, 1, "pre_b");
    wr(OFF_TXDATA, 8'h55, 1'b0, 0, "strb0");
    wr(5'h10, 8'h43, 1'b1, 0, "err_wr_10");
    wr(5'h00, 8'h44, 1'b1, 0, "err_wr_id");
    wr(5'h08, 8'h07, 1'b1, 0, "err_wr_status");
    rd(5'h04, "err_rd_txdata");
    rd(5'h14, "err_rd_14");
    rd(OFF_STATUS, "status_after_err");
    rd(OFF_CTRL, "ctrl_after_err");
    wr(OFF_CTRL, 8'h01, 1'b1, 0, "ctrl_on");
    wait_drain("drain_err");

    // Random mix of pushes, legal reads and illegal accesses while draining.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          if (exp_q.size() >= 12) repeat (8) @(posedge clk);
          else wr(OFF_TXDATA, 8'($urandom()), $urandom_range(0, 3) != 0, int'($urandom_range(0, 6)) - 3, "rnd_tx");
          #1;
        end
        3: begin
          case ($urandom_range(0, 3))
            0: rd(OFF_ID, "rnd_id");
            1: rd(OFF_CTRL, "rnd_ctrl");
            2: rd(OFF_TXDATA, "rnd_rd_txdata");
            default: rd(bad_offs[$urandom_range(0, 5)], "rnd_rd_unmapped");
          endcase
        end
        4: wr(bad_offs[$urandom_range(0, 7)], 8'($urandom()), 1'b1, int'($urandom_range(0, 4)) - 2, "rnd_err");
        default: begin
          repeat ($urandom_range(1, 6)) @(posedge clk);
          #1;
        end
      endcase
    end
    wait_drain("drain_rnd");
    rd(OFF_STATUS, "status_rnd_end");

    // Back-pressure on both responses, then reset in the middle of the stall.
    wr(OFF_CTRL, 8'h00, 1'b1, 0, "ctrl_off3");
    for (int i = 0; i < 3; i++) wr(OFF_TXDATA, 8'($urandom()), 1'b1, 0, "stall_fill");
    axi.b_ready = 0; axi.r_ready = 0;
    axi.aw_addr = 32'h0000_000C; axi.w_data = 32'h0; axi.w_strb = 4'hF; axi.ar_addr = 32'h0;
    axi.aw_valid = 1; axi.w_valid = 1; axi.ar_valid = 1;
    @(negedge clk);
    check("stall_start_ready", {axi.aw_ready, axi.w_ready, axi.ar_ready}, 3'b111);
    @(posedge clk); #1;
    axi.aw_valid = 0; axi.w_valid = 0; axi.ar_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold",
            {axi.b_valid, axi.r_valid, axi.aw_ready, axi.w_ready, axi.ar_ready, axi.b_resp, axi.r_resp, axi.r_data},
            {5'b11000, OKAY, OKAY, 32'h4355_4F4E});
    end
    rst_n = 1'b0;
    #1;
    check("midreset_outputs",
          {axi.aw_ready, axi.w_ready, axi.ar_ready, axi.b_valid, axi.r_valid, axi.b_resp, axi.r_resp, axi.r_data, tx_valid, tx_byte},
          {5'b11100, 4'b0000, 32'h0, 1'b0, 8'h00});
    exp_q.delete();
    model_ovf = 0;
    model_tx_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    axi.b_ready = 1; axi.r_ready = 1;
    @(posedge clk); #1;
    rd(OFF_STATUS, "status_post_reset");
    rd(OFF_CTRL, "ctrl_post_reset");
    repeat (40) @(posedge clk);
    #1;
    wr(OFF_TXDATA, 8'h21, 1'b1, -2, "tx_post_reset");
    wait_pulse("post_reset_lat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_console.md
# axil_console

AXI-Lite character-output peripheral for simulation and FPGA debug, replacing the single-register write-only console. It buffers characters in a parametrised TX FIFO and drains them at a programmable rate to a byte stream and, optionally, the simulator console. It provides readable ID/STATUS/CTRL registers and returns SLVERR for unmapped or illegal accesses. It sits on the system AXI-Lite interconnect as a leaf slave.

## Interface
- FIFO_DEPTH, 16: TX FIFO entries; power of two, ≥2
- DRAIN_DIV, 4: cycles between successive pops while draining; ≥1
- ECHO, 1: 1 = `$write("%c")` each popped byte (simulation only)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- axi  AXI_LITE.Slave  —  register port; decode on aw_addr/ar_addr[4:0]
- tx_valid_o  out  1  one-cycle pulse per popped byte
- tx_byte_o  out  8  popped byte, valid with tx_valid_o, held otherwise

## Operation
- Register map, word offsets; other bits of the address are ignored:
  - 0x00 ID: RO, 32'h4355_4F4E
  - 0x04 TXDATA: WO; push w_data[7:0] if w_strb[0], else no effect
  - 0x08 STATUS: RO
    - [0] empty, [1] full, [2] overflow (sticky)
    - [15:8] level, zero-extended
  - 0x0C CTRL: RW
    - [0] tx_en, reset 1
    - [1] clr_ovf: write 1 clears overflow; reads 0
- Responses:
  - SLVERR (2'b10) for unmapped offsets, writes to ID/STATUS, and reads of TXDATA; no side effect, r_data=0.
  - All other accesses return OKAY.
- Write channel: AW and W are captured independently.
  - aw_ready = ~aw_held; w_ready = ~w_held.
  - Once both are held, b_valid rises on the next edge and the write commits on that same edge.
  - b_valid holds until b_ready; on the b handshake both held flags clear.
- Read channel: ar_ready = ~r_valid.
  - On the ar handshake, r_data/r_resp are registered and r_valid is set.
  - r_valid holds until r_ready; one read is outstanding at most.
- TXDATA push while full, with no pop on the same edge: byte dropped, overflow set, response OKAY.
- Drain: while tx_en=1 and the FIFO is non-empty, a counter increments.
  - At DRAIN_DIV-1 the counter pops the FIFO, pulses tx_valid_o and resets to 0.
  - tx_en=0 freezes the counter.
  - When the FIFO is empty the counter is held at 0.

## Timing
- Reset values:
  - aw/w/ar_ready=1; b_valid=0, r_valid=0, b_resp=0, r_resp=0, r_data=0.
  - tx_valid_o=0, tx_byte_o=0.
  - FIFO empty, overflow=0, tx_en=1, counter=0.
- Reset mid-transaction: all pending channel state and FIFO contents are discarded; no response is issued.
- Write latency: AW+W in the same cycle (edge E) → b_valid high after E+1.
- Read latency: ar handshake at edge E → r_valid high after E.
- First byte: pushed at edge P → tx_valid_o high in the cycle after edge P+DRAIN_DIV (empty FIFO, tx_en=1).
- Simultaneous events:
  - Push and pop on the same edge when full: push accepted, level unchanged.
  - STATUS read on the same edge as push/pop returns the pre-edge value.
  - Overflow set and clr_ovf on the same edge: set wins.
- AW may lead W, or W lead AW, by any number of cycles; the second channel stays ready.

## Structure
- Package axil_console_pkg holds:
  - register offsets
  - AXI resp codes (OKAY, SLVERR)
  - ID constant
  - STATUS/CTRL bit positions
- Sub-module sync_fifo: parametrised WIDTH/DEPTH, push/pop/full/empty/level, async reset.
- The top module contains the AXI channel logic, decode, CTRL/overflow registers and the drain counter.

## Test plan
- Reset, then read 0x00 → r_resp OKAY, r_data 32'h4355_4F4E; read 0x08 → 32'h0000_0001.
- Write 0x48 then 0x69 to 0x04, AW two cycles before W → each b_resp OKAY; tx_valid_o pulses with 0x48 then 0x69, DRAIN_DIV cycles apart.
- tx_en=0, write 17 bytes (depth 16) → STATUS = level 16, full, overflow (32'h0000_1006); write CTRL=0x3 → STATUS 32'h0000_1002, drain resumes.
- Write 0x10, write 0x00, read 0x04, read 0x14 → all SLVERR; FIFO and registers unchanged.
- b_ready and r_ready held low 5 cycles → b_valid/r_valid stay high with stable data, aw/w/ar_ready stay low; assert rst_n low mid-stall → all outputs at reset values.
